imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder that sits at the far end of the fetch path and answers 64-bit aligned read requests issued by the fetch unit.
- Holds a word-addressed backing store mapped at BASE (0x8000_0000).
- Returns one 64-bit doubleword per request after a configurable latency over a valid/ready handshake; the fetch side selects the 32-bit half.
- A side load port lets the bench or loader preload the program image.

Parameters:
- DEPTH, 1024, number of 64-bit words in the backing store (power of 2, >= 2)
- BASE, 64'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from request acceptance to resp_valid (>= 1)
- IDX_W, $clog2(DEPTH), word index width (derived)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request
- req_addr  in  64  byte address of the fetch; bits [2:0] ignored
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_data  out  64  doubleword read from the store; 0 when resp_err=1
- resp_err  out  1  access fault: address outside [BASE, BASE+DEPTH*8)
- load_en  in  1  preload write strobe
- load_idx  in  IDX_W  word index to write
- load_data  in  64  word to write
- req_count  out  32  number of accepted requests; wraps modulo 2^32

Behaviour:
- Reset values: state IDLE, req_ready=1 after reset releases (0 while reset==0), resp_valid=0, resp_data=0, resp_err=0, req_count=0. Store contents are not cleared by reset.
- FSM states:
  - IDLE: req_ready=1. If req_valid, accept the request: latch {addr[63:3],3'b0}, increment req_count, load cnt=LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
  - WAIT: req_ready=0. Decrement cnt each cycle. When cnt==1, go to RESP on the next edge.
  - RESP: resp_valid=1. resp_data and resp_err are held stable until the cycle where resp_valid && resp_ready, then go to IDLE.
- Latency: accept in cycle T gives resp_valid=1 from cycle T+LATENCY. Back-to-back throughput is one request per LATENCY+1 cycles minimum.
- req_ready=0 in WAIT and RESP; only one request is outstanding at a time. A request cannot be accepted in the same cycle as a response handshake.
- Data capture happens on the edge that enters RESP.
  - In range: idx=(addr-BASE)>>3, resp_data=store[idx], resp_err=0.
  - Out of range (addr<BASE or addr>=BASE+DEPTH*8, unsigned 64-bit compare, no wraparound): resp_data=0, resp_err=1.
- Load port:
  - load_en writes store[load_idx] at the edge; the write is usable from the following cycle.
  - load_en is accepted in any state, including during reset.
  - If a load writes the captured index on the same edge as capture, the response carries the old value (read-before-write).
  - A load during WAIT before the capture edge is reflected in the response.
- Request fields (req_addr) are sampled only at acceptance; later changes are ignored.
- Reset mid-operation (WAIT or RESP): the in-flight request is dropped. The FSM goes to IDLE, resp_valid goes to 0 on the same edge, and req_count resets to 0.
- resp_ready held high with resp_valid low has no effect. resp_valid never drops without a handshake except on reset.

Decomposition:
- Shared package imem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - IMEM_BASE (64'h8000_0000)
  - XLEN=64
  - a function computing the in-range flag and index from an address
- Sub-module imem_array: DEPTH x 64 store with one synchronous write port (load) and one read port sampled at capture.
- The FSM, latency counter and req_count stay in imem_responder.

Test Plan:
- Preload store[0]=64'h0000_0013_0000_0093, LATENCY=2. Request addr 0x8000_0000 accepted at T -> resp_valid at T+2, resp_data=64'h0000_0013_0000_0093, resp_err=0, req_count=1.
- Request addr 0x8000_0004 -> same word 0 returned (low bits ignored).
- Request 0x7FFF_FFF8, then 0x8000_0000+DEPTH*8 -> resp_err=1, resp_data=0 both times. Last in-range word 0x8000_0000+(DEPTH-1)*8 -> resp_err=0.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/resp_data stay stable, req_ready=0. Raise resp_ready -> IDLE next cycle, req_ready=1.
- load_en to idx 0 during WAIT before the capture edge -> new value returned. load_en on the capture edge itself -> old value returned.
- Assert reset=0 in WAIT -> next edge resp_valid=0, req_ready=0 while held low, req_count=0. After release, a new request completes normally and the preloaded store is intact.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] IMEM_BASE = 64'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

    // Returns the doubleword index of addr relative to base. hit is set when
    // the address lies in [base, base + 2^idx_w * 8). The upper bound is
    // checked on the offset, so base near the top of the map cannot wrap.
    function automatic logic [XLEN-1:0] imem_decode(
        input  logic [XLEN-1:0] addr,
        input  logic [XLEN-1:0] base,
        input  int              idx_w,
        output logic            hit
    );
        logic [XLEN-1:0] off;
        off = addr - base;
        hit = (addr >= base) && ((off >> (idx_w + 3)) == '0);
        return off >> 3;
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 64 backing store: one synchronous write port, one registered read port.
import imem_pkg::*;

module imem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [XLEN-1:0]  rd_data
);

    logic [XLEN-1:0] mem [DEPTH];

    // Write and read share the edge; the read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding 64-bit read with fixed latency.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | req_ready=1, waiting for a fetch request
//   WAIT  | request latched, latency down-counter running
//   RESP  | resp_valid=1, data held until resp_ready handshake
import imem_pkg::*;

module imem_responder #(
    parameter int              DEPTH   = 1024,
    parameter logic [XLEN-1:0] BASE    = IMEM_BASE,
    parameter int              LATENCY = 2,
    parameter int              IDX_W   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic             resp_err,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [XLEN-1:0]  load_data,
    output logic [31:0]      req_count
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    imem_state_t      state;
    imem_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [XLEN-1:0]  addr_q;
    logic             err_q;
    logic             accept;
    logic             capture;
    logic [XLEN-1:0]  cap_addr;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_hit;
    logic [XLEN-1:0]  rd_data;

    assign req_ready  = (state == IDLE) && reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_data  = (resp_valid && !err_q) ? rd_data : '0;

    // With LATENCY==1 the capture edge is the accept edge, so the live address is used.
    always_comb begin
        cap_hit  = 1'b0;
        cap_addr = (state == IDLE) ? req_addr : addr_q;
        cap_idx  = IDX_W'(imem_decode(cap_addr, BASE, IDX_W, cap_hit));
    end

    // Next-state, latency down-counter and capture strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nxt = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    capture   = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter, latched request and fault flag; reset drops any in-flight request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            req_count <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q    <= req_addr;
                req_count <= req_count + 32'd1;
            end
            if (capture) begin
                err_q <= !cap_hit;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock   (clock),
        .wr_en   (load_en),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_en   (capture && reset),
        .rd_idx  (cap_idx),
        .rd_data (rd_data)
    );

endmodule
